// File: rtl/hazard_fwd_ctrl_pkg.sv
// rtl/hazard_fwd_ctrl_pkg.sv - shared types and constants for the hazard/forwarding controller
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int unsigned ZERO_REG = 0;

   function automatic logic [3:0] max_u4(input logic [3:0] a, input logic [3:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// rtl/hazard_fwd_ctrl_if.sv - pipeline-side signal bundle of the hazard/forwarding controller
interface hazard_fwd_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
);
   logic [RA_W-1:0]   id_rs_i;
   logic [RA_W-1:0]   id_rt_i;
   logic              id_use_rs_i;
   logic              id_use_rt_i;
   logic              id_branch_i;
   logic              branch_taken_i;
   logic              ex_regwrite_i;
   logic              ex_memread_i;
   logic [RA_W-1:0]   ex_rd_i;
   logic [RA_W-1:0]   ex_rs_i;
   logic [RA_W-1:0]   ex_rt_i;
   logic [DATA_W-1:0] ex_rs_data_i;
   logic [DATA_W-1:0] ex_rt_data_i;
   logic              mem_regwrite_i;
   logic              mem_memread_i;
   logic [RA_W-1:0]   mem_rd_i;
   logic [DATA_W-1:0] mem_alu_i;
   logic              wb_regwrite_i;
   logic [RA_W-1:0]   wb_rd_i;
   logic [DATA_W-1:0] wb_data_i;
   logic              dmem_busy_i;

   logic              pc_write_o;
   logic              if_id_write_o;
   logic              id_ex_bubble_o;
   logic              if_id_flush_o;
   logic              pipe_hold_o;
   logic [1:0]        fwd_a_o;
   logic [1:0]        fwd_b_o;
   logic [DATA_W-1:0] ex_a_o;
   logic [DATA_W-1:0] ex_b_o;
   logic              id_fwd_a_o;
   logic              id_fwd_b_o;

   modport slave (
      input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, id_branch_i, branch_taken_i,
             ex_regwrite_i, ex_memread_i, ex_rd_i, ex_rs_i, ex_rt_i, ex_rs_data_i, ex_rt_data_i,
             mem_regwrite_i, mem_memread_i, mem_rd_i, mem_alu_i,
             wb_regwrite_i, wb_rd_i, wb_data_i, dmem_busy_i,
      output pc_write_o, if_id_write_o, id_ex_bubble_o, if_id_flush_o, pipe_hold_o,
             fwd_a_o, fwd_b_o, ex_a_o, ex_b_o, id_fwd_a_o, id_fwd_b_o
   );

   modport master (
      output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, id_branch_i, branch_taken_i,
             ex_regwrite_i, ex_memread_i, ex_rd_i, ex_rs_i, ex_rt_i, ex_rs_data_i, ex_rt_data_i,
             mem_regwrite_i, mem_memread_i, mem_rd_i, mem_alu_i,
             wb_regwrite_i, wb_rd_i, wb_data_i, dmem_busy_i,
      input  pc_write_o, if_id_write_o, id_ex_bubble_o, if_id_flush_o, pipe_hold_o,
             fwd_a_o, fwd_b_o, ex_a_o, ex_b_o, id_fwd_a_o, id_fwd_b_o
   );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_mux.sv
// rtl/hazard_fwd_ctrl_fwd_mux.sv - per-operand EX forwarding match and 3:1 data mux
module fwd_mux
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
) (
   input  logic              i_en,
   input  logic [RA_W-1:0]   i_src,
   input  logic [DATA_W-1:0] i_reg_data,
   input  logic              i_mem_regwrite,
   input  logic [RA_W-1:0]   i_mem_rd,
   input  logic [DATA_W-1:0] i_mem_data,
   input  logic              i_wb_regwrite,
   input  logic [RA_W-1:0]   i_wb_rd,
   input  logic [DATA_W-1:0] i_wb_data,
   output logic [1:0]        o_sel,
   output logic [DATA_W-1:0] o_data
);
   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = i_mem_regwrite && (i_mem_rd != RA_W'(ZERO_REG)) && (i_mem_rd == i_src);
   assign w_wb_hit  = i_wb_regwrite && (i_wb_rd != RA_W'(ZERO_REG)) && (i_wb_rd == i_src);

   // MEM holds the younger result, so it shadows WB for the same register
   always_comb begin
      o_sel = FWD_REG;
      if (i_en) begin
         if (w_mem_hit) begin
            o_sel = FWD_MEM;
         end else if (w_wb_hit) begin
            o_sel = FWD_WB;
         end
      end
   end

   always_comb begin
      o_data = i_reg_data;
      case (o_sel)
         FWD_MEM: o_data = i_mem_data;
         FWD_WB:  o_data = i_wb_data;
         default: o_data = i_reg_data;
      endcase
   end
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - hazard stall, flush, hold and forwarding controller for the 5-stage pipe
module hazard_fwd_ctrl
   import pipe_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int RA_W     = 5,
   parameter int LOAD_LAT = 1
) (
   input logic              clk_i,
   input logic              rst_i,
   hazard_fwd_ctrl_if.slave bus
);
   localparam logic [3:0] LAT_N  = 4'(LOAD_LAT);
   localparam logic [3:0] LAT_N1 = 4'(LOAD_LAT + 1);

   state_t     r_state;
   state_t     r_saved;
   logic [2:0] r_cnt;
   state_t     w_state_nxt;
   state_t     w_saved_nxt;
   logic [2:0] w_cnt_nxt;
   state_t     w_eff;

   logic       w_ex_hit;
   logic       w_mem_hit;
   logic [3:0] w_n_load;
   logic [3:0] w_n_br_alu;
   logic [3:0] w_n_br_exld;
   logic [3:0] w_n_br_memld;
   logic [3:0] w_need;
   logic       w_stall;
   logic       w_flush;
   logic       w_hold;

   assign w_ex_hit = (bus.ex_rd_i != RA_W'(ZERO_REG)) &&
                     ((bus.id_use_rs_i && (bus.id_rs_i == bus.ex_rd_i)) ||
                      (bus.id_use_rt_i && (bus.id_rt_i == bus.ex_rd_i)));
   assign w_mem_hit = (bus.mem_rd_i != RA_W'(ZERO_REG)) &&
                      ((bus.id_use_rs_i && (bus.id_rs_i == bus.mem_rd_i)) ||
                       (bus.id_use_rt_i && (bus.id_rt_i == bus.mem_rd_i)));

   assign w_n_load     = (bus.ex_memread_i && w_ex_hit) ? LAT_N : 4'd0;
   assign w_n_br_alu   = (bus.id_branch_i && bus.ex_regwrite_i && !bus.ex_memread_i && w_ex_hit) ? 4'd1 : 4'd0;
   assign w_n_br_exld  = (bus.id_branch_i && bus.ex_memread_i && w_ex_hit) ? LAT_N1 : 4'd0;
   assign w_n_br_memld = (bus.id_branch_i && bus.mem_memread_i && w_mem_hit) ? LAT_N : 4'd0;
   assign w_need       = max_u4(max_u4(w_n_load, w_n_br_alu), max_u4(w_n_br_exld, w_n_br_memld));

   // Once busy drops, HOLD behaves as the state it interrupted within the same cycle
   assign w_eff = (r_state == HOLD) ? r_saved : r_state;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= RUN;
         r_saved <= RUN;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_saved <= w_saved_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_saved_nxt = r_saved;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      w_flush     = 1'b0;
      w_hold      = 1'b0;
      if (bus.dmem_busy_i) begin
         w_hold      = 1'b1;
         w_state_nxt = HOLD;
         if (r_state != HOLD) begin
            w_saved_nxt = r_state;
         end
      end else begin
         w_state_nxt = w_eff;
         case (w_eff)
            STALL: begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt - 3'd1;
               if (r_cnt <= 3'd1) begin
                  w_state_nxt = RUN;
               end
            end
            default: begin
               if (w_need != 4'd0) begin
                  w_stall = 1'b1;
                  if (w_need > 4'd1) begin
                     w_cnt_nxt   = 3'(w_need - 4'd1);
                     w_state_nxt = STALL;
                  end
               end else begin
                  w_flush = bus.branch_taken_i;
               end
            end
         endcase
      end
   end

   assign bus.pc_write_o     = rst_i && !w_stall && !w_hold;
   assign bus.if_id_write_o  = rst_i && !w_stall && !w_hold;
   assign bus.id_ex_bubble_o = !rst_i || w_stall;
   assign bus.if_id_flush_o  = rst_i && w_flush;
   assign bus.pipe_hold_o    = rst_i && w_hold;

   assign bus.id_fwd_a_o = rst_i && bus.mem_regwrite_i && !bus.mem_memread_i &&
                           (bus.mem_rd_i != RA_W'(ZERO_REG)) && (bus.mem_rd_i == bus.id_rs_i);
   assign bus.id_fwd_b_o = rst_i && bus.mem_regwrite_i && !bus.mem_memread_i &&
                           (bus.mem_rd_i != RA_W'(ZERO_REG)) && (bus.mem_rd_i == bus.id_rt_i);

   fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_a (
      .i_en           (rst_i),
      .i_src          (bus.ex_rs_i),
      .i_reg_data     (bus.ex_rs_data_i),
      .i_mem_regwrite (bus.mem_regwrite_i),
      .i_mem_rd       (bus.mem_rd_i),
      .i_mem_data     (bus.mem_alu_i),
      .i_wb_regwrite  (bus.wb_regwrite_i),
      .i_wb_rd        (bus.wb_rd_i),
      .i_wb_data      (bus.wb_data_i),
      .o_sel          (bus.fwd_a_o),
      .o_data         (bus.ex_a_o)
   );

   fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_b (
      .i_en           (rst_i),
      .i_src          (bus.ex_rt_i),
      .i_reg_data     (bus.ex_rt_data_i),
      .i_mem_regwrite (bus.mem_regwrite_i),
      .i_mem_rd       (bus.mem_rd_i),
      .i_mem_data     (bus.mem_alu_i),
      .i_wb_regwrite  (bus.wb_regwrite_i),
      .i_wb_rd        (bus.wb_rd_i),
      .i_wb_data      (bus.wb_data_i),
      .o_sel          (bus.fwd_b_o),
      .o_data         (bus.ex_b_o)
   );
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - self-checking bench: vector table, corner sequences, random vs model
module tb_hazard_fwd_ctrl;
   import pipe_pkg::*;

   localparam int NL = 4;

   typedef struct packed {
      logic [4:0]  id_rs, id_rt;
      logic        use_rs, use_rt, branch, taken;
      logic        ex_rw, ex_mr;
      logic [4:0]  ex_rd, ex_rs, ex_rt;
      logic [31:0] ex_rs_data, ex_rt_data;
      logic        mem_rw, mem_mr;
      logic [4:0]  mem_rd;
      logic [31:0] mem_alu;
      logic        wb_rw;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      logic        busy;
   } in_t;

   typedef struct packed {
      logic        pc_write, if_id_write, bubble, flush, hold;
      logic [1:0]  fa, fb;
      logic [31:0] a, b;
      logic        ida, idb;
   } out_t;

   typedef struct packed {
      in_t         i;
      logic        pc, fl;
      logic [1:0]  fa, fb;
      logic [31:0] a, b;
      logic        ida;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   in_t  cur;
   out_t obs [NL];
   out_t smp [NL];
   int   rem [NL];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NL; g++) begin : g_lane
      hazard_fwd_ctrl_if #(.DATA_W(32), .RA_W(5)) u_if ();
      assign u_if.id_rs_i        = cur.id_rs;
      assign u_if.id_rt_i        = cur.id_rt;
      assign u_if.id_use_rs_i    = cur.use_rs;
      assign u_if.id_use_rt_i    = cur.use_rt;
      assign u_if.id_branch_i    = cur.branch;
      assign u_if.branch_taken_i = cur.taken;
      assign u_if.ex_regwrite_i  = cur.ex_rw;
      assign u_if.ex_memread_i   = cur.ex_mr;
      assign u_if.ex_rd_i        = cur.ex_rd;
      assign u_if.ex_rs_i        = cur.ex_rs;
      assign u_if.ex_rt_i        = cur.ex_rt;
      assign u_if.ex_rs_data_i   = cur.ex_rs_data;
      assign u_if.ex_rt_data_i   = cur.ex_rt_data;
      assign u_if.mem_regwrite_i = cur.mem_rw;
      assign u_if.mem_memread_i  = cur.mem_mr;
      assign u_if.mem_rd_i       = cur.mem_rd;
      assign u_if.mem_alu_i      = cur.mem_alu;
      assign u_if.wb_regwrite_i  = cur.wb_rw;
      assign u_if.wb_rd_i        = cur.wb_rd;
      assign u_if.wb_data_i      = cur.wb_data;
      assign u_if.dmem_busy_i    = cur.busy;
      assign obs[g] = {u_if.pc_write_o, u_if.if_id_write_o, u_if.id_ex_bubble_o, u_if.if_id_flush_o,
                       u_if.pipe_hold_o, u_if.fwd_a_o, u_if.fwd_b_o, u_if.ex_a_o, u_if.ex_b_o,
                       u_if.id_fwd_a_o, u_if.id_fwd_b_o};
      hazard_fwd_ctrl #(.DATA_W(32), .RA_W(5), .LOAD_LAT(g == 3 ? 7 : g + 1)) u_dut (
         .clk_i (clk),
         .rst_i (rst_n),
         .bus   (u_if.slave)
      );
   end

   function automatic int lat_of(input int g);
      return (g == 3) ? 7 : g + 1;
   endfunction

   function automatic logic hitf(input in_t x, input logic [4:0] r);
      return (r != 0) && ((x.use_rs && x.id_rs == r) || (x.use_rt && x.id_rt == r));
   endfunction

   // Bubbles required by the instruction in ID: largest of all active hazard terms
   function automatic int need(input in_t x, input int lat);
      int n = 0;
      if (x.ex_mr && hitf(x, x.ex_rd) && lat > n) n = lat;
      if (x.branch && x.ex_rw && !x.ex_mr && hitf(x, x.ex_rd) && 1 > n) n = 1;
      if (x.branch && x.ex_mr && hitf(x, x.ex_rd) && lat + 1 > n) n = lat + 1;
      if (x.branch && x.mem_mr && hitf(x, x.mem_rd) && lat > n) n = lat;
      return n;
   endfunction

   function automatic logic [1:0] fsel(input logic [4:0] src, input in_t x);
      if (x.mem_rw && x.mem_rd != 0 && x.mem_rd == src) return FWD_MEM;
      if (x.wb_rw && x.wb_rd != 0 && x.wb_rd == src) return FWD_WB;
      return FWD_REG;
   endfunction

   function automatic logic [31:0] fdata(input logic [1:0] s, input logic [31:0] rv, input in_t x);
      if (s == FWD_MEM) return x.mem_alu;
      if (s == FWD_WB) return x.wb_data;
      return rv;
   endfunction

   // rin = bubbles still owed by an earlier hazard; a busy memory only postpones them
   function automatic out_t model(input in_t x, input logic rst, input int lat, input int rin,
                                  output int rout);
      out_t o;
      int   n;
      o = '0;
      rout = rin;
      o.a = x.ex_rs_data;
      o.b = x.ex_rt_data;
      if (!rst) begin
         o.bubble = 1'b1;
         rout = 0;
         return o;
      end
      o.fa  = fsel(x.ex_rs, x);
      o.fb  = fsel(x.ex_rt, x);
      o.a   = fdata(o.fa, x.ex_rs_data, x);
      o.b   = fdata(o.fb, x.ex_rt_data, x);
      o.ida = x.mem_rw && !x.mem_mr && x.mem_rd != 0 && x.mem_rd == x.id_rs;
      o.idb = x.mem_rw && !x.mem_mr && x.mem_rd != 0 && x.mem_rd == x.id_rt;
      if (x.busy) begin
         o.hold = 1'b1;
      end else if (rin > 0) begin
         o.bubble = 1'b1;
         rout = rin - 1;
      end else begin
         n = need(x, lat);
         if (n > 0) begin
            o.bubble = 1'b1;
            rout = n - 1;
         end else begin
            o.pc_write = 1'b1;
            o.if_id_write = 1'b1;
            o.flush = x.taken;
         end
      end
      return o;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step(input bit cmp);
      @(negedge clk);
      for (int g = 0; g < NL; g++) begin
         int   rn;
         out_t e;
         smp[g] = obs[g];
         e = model(cur, rst_n, lat_of(g), rem[g], rn);
         if (cmp) check($sformatf("rand_lane%0d", g), 128'(obs[g]), 128'(e));
         rem[g] = rn;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      cur = '0;
      repeat (10) step(1'b0);
   endtask

   function automatic in_t fw(input logic [4:0] ers, input logic [4:0] ert, input logic [31:0] rsd,
                              input logic [31:0] rtd, input logic mrw, input logic [4:0] mrd,
                              input logic [31:0] malu, input logic wrw, input logic [4:0] wrd,
                              input logic [31:0] wd);
      in_t x = '0;
      x.ex_rs = ers; x.ex_rt = ert; x.ex_rs_data = rsd; x.ex_rt_data = rtd;
      x.mem_rw = mrw; x.mem_rd = mrd; x.mem_alu = malu;
      x.wb_rw = wrw; x.wb_rd = wrd; x.wb_data = wd;
      return x;
   endfunction

   function automatic in_t hz(input in_t b, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic br, input logic tk,
                              input logic erw, input logic emr, input logic [4:0] erd,
                              input logic mmr);
      in_t x = b;
      x.id_rs = rs; x.id_rt = rt; x.use_rs = urs; x.use_rt = urt; x.branch = br; x.taken = tk;
      x.ex_rw = erw; x.ex_mr = emr; x.ex_rd = erd; x.mem_mr = mmr;
      return x;
   endfunction

   function automatic vec_t vec(input in_t i, input logic pc, input logic fl, input logic [1:0] fa,
                                input logic [1:0] fb, input logic [31:0] a, input logic [31:0] b,
                                input logic ida);
      vec_t v;
      v.i = i; v.pc = pc; v.fl = fl; v.fa = fa; v.fb = fb; v.a = a; v.b = b; v.ida = ida;
      return v;
   endfunction

   function automatic in_t load_use();
      return hz('0, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
   endfunction

   initial begin
      vec_t      tbl[$];
      in_t       base;
      logic [9:0] m_pc [NL];
      logic [5:0] h_hold, h_bub, h_pc1, h_pc0;
      logic [2:0] b_fl;

      for (int g = 0; g < NL; g++) rem[g] = 0;
      rst_n = 1'b0;
      cur = hz(fw(5'd2, 5'd2, 32'hA5A5, 32'h5A5A, 1'b1, 5'd2, 32'h11, 1'b1, 5'd2, 32'h22),
               5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
      step(1'b0);
      check("reset_lane0", 128'(smp[0]), 128'({5'b00100, 4'b0000, 32'hA5A5, 32'h5A5A, 2'b00}));
      check("reset_lane3", 128'(smp[3]), 128'({5'b00100, 4'b0000, 32'hA5A5, 32'h5A5A, 2'b00}));
      rst_n = 1'b1;
      drain();

      base = '0;
      tbl.push_back(vec(fw(5'd2, 5'd2, 32'hAAAA, 32'hBBBB, 1'b1, 5'd2, 32'h11, 1'b1, 5'd2, 32'h22),
                        1'b1, 1'b0, 2'b10, 2'b10, 32'h11, 32'h11, 1'b0));
      tbl.push_back(vec(fw(5'd0, 5'd3, 32'h1234, 32'h5678, 1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'h0),
                        1'b1, 1'b0, 2'b00, 2'b00, 32'h1234, 32'h5678, 1'b0));
      tbl.push_back(vec(fw(5'd2, 5'd4, 32'h1, 32'h2, 1'b0, 5'd2, 32'h33, 1'b1, 5'd2, 32'hDEADBEEF),
                        1'b1, 1'b0, 2'b01, 2'b00, 32'hDEADBEEF, 32'h2, 1'b0));
      tbl.push_back(vec(fw(5'd5, 5'd6, 32'h7, 32'h8, 1'b1, 5'd6, 32'hFFFFFFFF, 1'b1, 5'd5, 32'h80000000),
                        1'b1, 1'b0, 2'b01, 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0));
      tbl.push_back(vec(fw(5'd0, 5'd0, 32'h9, 32'hA, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h44),
                        1'b1, 1'b0, 2'b00, 2'b00, 32'h9, 32'hA, 1'b0));
      tbl.push_back(vec(hz(base, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0),
                        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0));
      tbl.push_back(vec(hz(base, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0),
                        1'b1, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0));
      tbl.push_back(vec(hz(base, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0),
                        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0));
      tbl.push_back(vec(hz(base, 5'd2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0),
                        1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0));
      tbl.push_back(vec(hz(base, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0),
                        1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0));
      tbl.push_back(vec(hz(fw(5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0),
                           5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0),
                        1'b1, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1));
      tbl.push_back(vec(hz(fw(5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0),
                           5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1),
                        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0));
      foreach (tbl[i]) begin
         cur = tbl[i].i;
         step(1'b0);
         check($sformatf("vec%0d", i),
               128'({smp[0].pc_write, smp[0].flush, smp[0].fa, smp[0].fb, smp[0].a, smp[0].b, smp[0].ida}),
               128'({tbl[i].pc, tbl[i].fl, tbl[i].fa, tbl[i].fb, tbl[i].a, tbl[i].b, tbl[i].ida}));
      end

      // Load-use: exactly LOAD_LAT stall cycles from the detection cycle, for each lane
      drain();
      for (int g = 0; g < NL; g++) m_pc[g] = '0;
      for (int c = 0; c < 10; c++) begin
         cur = load_use();
         if (c > 0) begin cur.ex_rw = 1'b0; cur.ex_mr = 1'b0; cur.ex_rd = 5'd0; end
         if (c == 1) begin cur.mem_rw = 1'b1; cur.mem_mr = 1'b1; cur.mem_rd = 5'd2; end
         step(1'b0);
         for (int g = 0; g < NL; g++) m_pc[g][c] = !smp[g].pc_write;
      end
      for (int g = 0; g < NL; g++)
         check($sformatf("loaduse_stalls_lat%0d", lat_of(g)), 128'(m_pc[g]), 128'((1 << lat_of(g)) - 1));
      cur = fw(5'd2, 5'd0, 32'h99, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h77);
      step(1'b0);
      check("loaduse_wb_fwd", 128'({smp[0].fa, smp[0].a}), 128'({2'b01, 32'h77}));

      // Compare-in-ID branch on an EX ALU result, then ID forwarding and a one-cycle flush
      drain();
      b_fl = '0;
      cur = hz('0, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0);
      step(1'b0);
      b_fl[0] = smp[0].flush;
      check("br_stall", 128'({smp[0].pc_write, smp[0].bubble}), 128'(2'b01));
      cur = hz(fw(5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd2, 32'h1234, 1'b0, 5'd0, 32'h0),
               5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      step(1'b0);
      b_fl[1] = smp[0].flush;
      check("br_id_fwd", 128'({smp[0].ida, smp[0].idb, smp[0].pc_write}), 128'(3'b101));
      cur = '0;
      step(1'b0);
      b_fl[2] = smp[0].flush;
      check("br_flush_pulse", 128'(b_fl), 128'(3'b010));

      // Memory busy for three cycles in the middle of a LOAD_LAT=2 stall
      drain();
      h_hold = '0; h_bub = '0; h_pc1 = '0; h_pc0 = '0;
      for (int c = 0; c < 6; c++) begin
         cur = (c == 0) ? load_use() : '0;
         cur.busy = (c >= 1 && c <= 3);
         step(1'b0);
         h_hold[c] = smp[1].hold;
         h_bub[c]  = smp[1].bubble;
         h_pc1[c]  = smp[1].pc_write;
         h_pc0[c]  = smp[0].pc_write;
      end
      check("hold_pipe_hold", 128'(h_hold), 128'(6'b001110));
      check("hold_bubble", 128'(h_bub), 128'(6'b010001));
      check("hold_pc_write_lat2", 128'(h_pc1), 128'(6'b100000));
      check("hold_pc_write_lat1", 128'(h_pc0), 128'(6'b110000));

      // Reset in the middle of a hold drops the owed bubble
      drain();
      cur = load_use();
      step(1'b0);
      cur = '0;
      cur.busy = 1'b1;
      step(1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_hold", 128'({obs[1].pc_write, obs[1].bubble, obs[1].hold, obs[1].flush}),
            128'(4'b0100));
      step(1'b0);
      rst_n = 1'b1;
      cur = '0;
      step(1'b0);
      check("rst_discards_stall", 128'({smp[1].pc_write, smp[1].bubble}), 128'(2'b10));

      for (int n = 0; n < 3000; n++) begin
         in_t x;
         x.id_rs = 5'($urandom_range(0, 3));       x.id_rt = 5'($urandom_range(0, 3));
         x.use_rs = 1'($urandom);                  x.use_rt = 1'($urandom);
         x.branch = 1'($urandom);                  x.taken = 1'($urandom);
         x.ex_rw = 1'($urandom);                   x.ex_mr = ($urandom_range(0, 3) == 0);
         x.ex_rd = 5'($urandom_range(0, 3));       x.ex_rs = 5'($urandom_range(0, 3));
         x.ex_rt = 5'($urandom_range(0, 3));       x.ex_rs_data = $urandom;
         x.ex_rt_data = $urandom;                  x.mem_rw = 1'($urandom);
         x.mem_mr = ($urandom_range(0, 3) == 0);   x.mem_rd = 5'($urandom_range(0, 3));
         x.mem_alu = $urandom;                     x.wb_rw = 1'($urandom);
         x.wb_rd = 5'($urandom_range(0, 3));       x.wb_data = $urandom;
         x.busy = ($urandom_range(0, 7) == 0);
         cur = x;
         rst_n = ($urandom_range(0, 99) != 0);
         step(1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Parametrised hazard, forwarding and flush controller for the 5-stage pipelined CPU. It replaces the separate single-cycle hazard-detection and forwarding units with one block. The block adds a configurable load-use latency, stall-on-branch-dependence for the ID-stage comparator, and a global pipeline hold while data memory is busy. It sits beside the pipeline registers and drives their write, bubble and flush controls every cycle.

## Interface
- `DATA_W`, default 32: operand width.
- `RA_W`, default 5: register-address width. Address 0 is hard-wired zero and is never forwarded.
- `LOAD_LAT`, default 1 (range 1–7): bubbles inserted for a load-use hazard.
- `clk_i` in 1: clock. All state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `id_rs_i`, `id_rt_i` in RA_W: source registers of the instruction in ID.
- `id_use_rs_i`, `id_use_rt_i` in 1: the instruction in ID actually reads rs / rt.
- `id_branch_i` in 1: the instruction in ID is a compare-in-ID branch.
- `branch_taken_i` in 1: the ID comparator resolved taken (branch or jump).
- `ex_regwrite_i`, `ex_memread_i` in 1: EX-stage control bits.
- `ex_rd_i` in RA_W: EX-stage destination register.
- `ex_rs_i`, `ex_rt_i` in RA_W: EX-stage source registers.
- `ex_rs_data_i`, `ex_rt_data_i` in DATA_W: register-file values latched in ID/EX.
- `mem_regwrite_i`, `mem_memread_i` in 1: MEM-stage control bits.
- `mem_rd_i` in RA_W: MEM-stage destination register.
- `mem_alu_i` in DATA_W: MEM-stage ALU result.
- `wb_regwrite_i` in 1, `wb_rd_i` in RA_W, `wb_data_i` in DATA_W: write-back port.
- `dmem_busy_i` in 1: data memory cannot complete this cycle.
- `pc_write_o` out 1: PC may update.
- `if_id_write_o` out 1: IF/ID may load.
- `id_ex_bubble_o` out 1: zero the ID/EX control bits.
- `if_id_flush_o` out 1: zero the IF/ID instruction.
- `pipe_hold_o` out 1: freeze every pipeline register.
- `fwd_a_o`, `fwd_b_o` out 2: EX forwarding selects.
- `ex_a_o`, `ex_b_o` out DATA_W: forwarded EX operands.
- `id_fwd_a_o`, `id_fwd_b_o` out 1: feed `mem_alu_i` to the ID comparator.

## Operation
- **State machine** `{RUN, STALL, HOLD}`, with a 3-bit down-counter `cnt` and a saved return state.
- **Hazard terms.** `hit(r) = (r != 0) && ((id_use_rs_i && id_rs_i == r) || (id_use_rt_i && id_rt_i == r))`.
  - Load-use: `ex_memread_i && hit(ex_rd_i)` needs LOAD_LAT bubbles.
  - Branch on EX ALU result: `id_branch_i && ex_regwrite_i && !ex_memread_i && hit(ex_rd_i)` needs 1 bubble.
  - Branch on EX load: `id_branch_i && ex_memread_i && hit(ex_rd_i)` needs LOAD_LAT+1 bubbles.
  - Branch on MEM load: `id_branch_i && mem_memread_i && hit(mem_rd_i)` needs LOAD_LAT bubbles.
  - When several terms are active, the largest bubble count wins.
- **RUN**
  - Hazard of N bubbles: assert the stall outputs this cycle (`pc_write_o = 0`, `if_id_write_o = 0`, `id_ex_bubble_o = 1`). If N > 1, set `cnt <= N-1` and go to STALL.
  - No hazard and `branch_taken_i`: assert `if_id_flush_o` for that cycle.
- **STALL**
  - Stall outputs stay asserted.
  - `cnt` decrements each cycle. On the cycle `cnt == 1`, return to RUN.
  - Hazards are re-evaluated on return to RUN.
- **HOLD**
  - Entered from any state whenever `dmem_busy_i = 1`. The prior state and `cnt` are saved.
  - Outputs: `pipe_hold_o = 1`, `pc_write_o = 0`, `if_id_write_o = 0`, `id_ex_bubble_o = 0`, `if_id_flush_o = 0`.
  - `cnt` is frozen. On `dmem_busy_i = 0`, return to the saved state.
- **Priority:** `dmem_busy_i` > active STALL > new hazard > flush. `branch_taken_i` is ignored while stalled or held.
- **EX forwarding (per operand)**
  - `10`: MEM match, i.e. `mem_regwrite_i && mem_rd_i != 0 && mem_rd_i == src`.
  - `01`: WB match under the same rule.
  - `00`: neither. MEM has priority over WB.
  - `ex_a_o` / `ex_b_o` select between the register value, `mem_alu_i` and `wb_data_i`; all are DATA_W wide with no extension.
- **ID forwarding:** `id_fwd_*` = MEM match (non-load) against `id_rs_i` / `id_rt_i`.

## Timing
- Forwarding selects, forwarded data and all stall/flush/hold outputs are combinational from current state and inputs. State, `cnt` and the saved state are registered.
- Reset (`rst_i = 0`): state = RUN, `cnt = 0`. While reset is asserted, outputs are forced to `pc_write_o = 0`, `if_id_write_o = 0`, `id_ex_bubble_o = 1`, `if_id_flush_o = 0`, `pipe_hold_o = 0`, `fwd_* = 00`, `id_fwd_* = 0`.
- Reset asserted mid-STALL or mid-HOLD discards the remaining bubbles.
- Load-use with LOAD_LAT = L: exactly L consecutive stall cycles, starting in the cycle of detection.
- Flush is a single cycle. It coincides with the IF/ID edge that would have captured the wrong-path instruction.

## Structure
- Package `pipe_pkg`: the state enum, the forward-select constants (`FWD_REG = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`) and the zero-register constant.
- One sub-module, `fwd_mux`, instantiated twice. It contains the per-operand match logic and the 3:1 data mux.

## Test plan
- LOAD_LAT = 1, `lw $2` in EX, `add $3,$2,$4` in ID → one cycle with `pc_write_o = 0`, `id_ex_bubble_o = 1`; next cycle `fwd_a_o = 01`.
- LOAD_LAT = 3, same load-use pair → exactly 3 stall cycles, then RUN.
- MEM and WB both write $2 (values 0x11 / 0x22), EX reads $2 on both operands → `fwd_a_o = fwd_b_o = 10`, `ex_a_o = 0x11`.
- MEM writes $0 with `mem_alu_i = 5` → `fwd_a_o = 00`, `ex_a_o = ex_rs_data_i`.
- `beq $2,$3` in ID with `add $2` in EX → 1 stall; next cycle `id_fwd_a_o = 1`; with `branch_taken_i = 1`, `if_id_flush_o` pulses for one cycle.
- LOAD_LAT = 2, `dmem_busy_i` raised for 3 cycles during STALL → `pipe_hold_o = 1` for 3 cycles, then the remaining stall cycle. Assert `rst_i = 0` mid-hold on a second run → reset values immediately.
